// File: rtl/memory_arbiter_pkg.sv
// Shared types and sizes for the two-requester memory/MMIO arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;

endpackage

// File: rtl/arb_timeout_counter.sv
// Saturating count of ISSUE cycles; flags the cycle that reaches TIMEOUT_CYCLES.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // cnt_q holds completed ISSUE cycles, so the current cycle is number cnt_q+1.
  assign expired = count_en && ((9'(cnt_q) + 9'd1) == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory_controller port between two requesters.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  hwclk,
  input  logic                  nrst,
  input  logic [NUM_REQ-1:0]    req_read_en,
  input  logic [NUM_REQ-1:0]    req_write_en,
  input  logic [NUM_REQ-1:0]    req_dbl_byte_en,
  input  logic [2*ADDR_W-1:0]   req_address,
  input  logic [2*DATA_W-1:0]   req_data_in,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [DATA_W-1:0]     req_data_out,
  output logic [NUM_REQ-1:0]    req_error,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic                  dbl_byte_en,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W-1:0]     data_in,
  input  logic                  ack,
  input  logic [DATA_W-1:0]     data_output,
  output logic                  grant,
  output logic                  busy
);

  arb_state_t state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       expired;

  logic [NUM_REQ-1:0] pend;
  logic               in_issue;
  logic               own_re, own_we, own_dbl;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_data;

  assign pend     = req_read_en | req_write_en;
  assign in_issue = (state_q == ISSUE);
  assign own_re   = req_read_en[grant_q];
  assign own_we   = req_write_en[grant_q];
  assign own_dbl  = req_dbl_byte_en[grant_q];
  assign own_addr = grant_q ? req_address[2*ADDR_W-1:ADDR_W] : req_address[ADDR_W-1:0];
  assign own_data = grant_q ? req_data_in[2*DATA_W-1:DATA_W] : req_data_in[DATA_W-1:0];

  // A read+write request is treated as a write.
  assign mem_write_en = in_issue & own_we;
  assign mem_read_en  = in_issue & own_re & ~own_we;
  assign dbl_byte_en  = in_issue & own_dbl;
  assign address      = in_issue ? own_addr : '0;
  assign data_in      = in_issue ? own_data : '0;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (hwclk),
    .rst_n   (nrst),
    .clear   (!in_issue),
    .count_en(in_issue),
    .expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_ack      = '0;
    req_error    = '0;
    req_data_out = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend) begin
          grant_d      = (pend == 2'b11) ? ~last_grant_q : pend[1];
          last_grant_d = grant_d;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Completion wins over both a dropped request and the timeout limit.
        if (ack) begin
          req_ack[grant_q] = 1'b1;
          req_data_out     = data_output;
          state_d          = RELEASE;
        end else if (!(own_re || own_we)) begin
          state_d = RELEASE;
        end else if (expired) begin
          req_ack[grant_q]   = 1'b1;
          req_error[grant_q] = 1'b1;
          state_d            = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter placed in front of `memory_controller`. It shares the single memory/MMIO request port between requester 0 (CPU core) and requester 1 (program loader / debug port). It grants one transaction at a time using round-robin priority and forwards the owner's request unchanged. It returns `ack` and read data only to the owner, and aborts transactions that never complete.

## Interface
- `TIMEOUT_CYCLES`, default 255: ISSUE cycles without downstream `ack` before an abort (1..255).
- `hwclk` in 1: the single clock.
- `nrst` in 1: asynchronous, active-low reset.
- `req_read_en` in [1:0]: per-requester read request; bit i is requester i.
- `req_write_en` in [1:0]: per-requester write request.
- `req_dbl_byte_en` in [1:0]: per-requester 16-bit access select.
- `req_address` in [31:0]: requester i address at bits [16i+15:16i].
- `req_data_in` in [31:0]: requester i write data, same packing as `req_address`.
- `req_ack` out [1:0]: one-cycle completion pulse to the owner.
- `req_data_out` out [15:0]: read data, valid only while a `req_ack` bit is high; 0 otherwise.
- `req_error` out [1:0]: one-cycle pulse alongside `req_ack` when the transaction timed out.
- `mem_read_en`, `mem_write_en`, `dbl_byte_en` out 1: downstream request to `memory_controller`.
- `address`, `data_in` out 16: downstream address and write data.
- `ack` in 1: downstream completion.
- `data_output` in 16: downstream read data.
- `grant` out 1: index of the current owner; holds its last value outside ISSUE.
- `busy` out 1: high in ISSUE and RELEASE.

## Operation
- States:
  - IDLE: downstream enables low.
  - ISSUE: owner's request forwarded combinationally.
  - RELEASE: one cycle with downstream enables low, so `memory_controller` byte counter and `ack` clear.
- A requester is pending when `read_en|write_en` is set.
- IDLE arbitration:
  - If none is pending, stay in IDLE.
  - If one is pending, grant it.
  - If both are pending, grant the requester ≠ `last_grant`.
  - Register `grant`, update `last_grant` and go to ISSUE.
- Request encoding: `read_en` and `write_en` both high is a write; downstream `mem_read_en` is forced 0.
- ISSUE with `ack`=1:
  - `req_ack[grant]`=1 and `req_data_out`=`data_output` in the same cycle (combinational pass-through).
  - Go to RELEASE.
- ISSUE with the owner's enables both dropped before `ack`: abort silently (no `req_ack`) and go to RELEASE.
- ISSUE timeout: the timeout counter counts ISSUE cycles. When it equals `TIMEOUT_CYCLES` without `ack`:
  - Pulse `req_ack[grant]` and `req_error[grant]`, with `req_data_out`=0.
  - Go to RELEASE.
- RELEASE -> IDLE unconditionally; the counter clears.
- Requesters must drop their enables in the cycle after `req_ack`. An enable still high in IDLE is a new request.
- The non-owner's `req_ack`/`req_error` are always 0. Its request waits, with inputs held.
- Requester inputs must stay stable while granted; the arbiter does not latch them.

## Timing
- Reset values:
  - State IDLE, `grant`=0, `last_grant`=1 (requester 0 wins the first tie), counter 0.
  - All outputs 0, including `busy`.
- Request seen at cycle 0 in IDLE: downstream enables high at cycle 1.
- MMIO access (`ack` combinational from `memory_controller`): `req_ack` at cycle 1, RELEASE at cycle 2, IDLE at cycle 3.
- Minimum spacing is 3 cycles per transaction. External memory adds the `memory_controller` completion latency.
- Under sustained contention, grants strictly alternate 0,1,0,1.
- Timeout: the error pulse occurs in the `TIMEOUT_CYCLES`-th ISSUE cycle. The counter saturates and never wraps.
- `ack` in the same cycle as the timeout limit: normal completion, `req_error`=0.
- `ack` in the same cycle as the enables drop: completion takes precedence and `req_ack` is pulsed.
- Reset asserted mid-ISSUE: downstream enables and `req_ack` drop immediately (asynchronous). No completion is reported after reset.

## Structure
- Package `memory_arbiter_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, RELEASE}.
  - `NUM_REQ`=2.
  - Localparams for address and data widths (16).
- One sub-module, `arb_timeout_counter`:
  - 8-bit saturating up-counter with inputs `clear`/`count_en`.
  - `expired` output compares against `TIMEOUT_CYCLES`.
- Top level holds the FSM, `last_grant`, and the request/response muxes.

## Test plan
- Single read, requester 0 to 0xFFA3 with `ack` tied combinational and `data_output`=0x005A:
  - `mem_read_en` and `address`=0xFFA3 at cycle 1.
  - `req_ack`=2'b01 and `req_data_out`=0x005A at cycle 1.
  - `busy` low at cycle 3.
- Both requesters write continuously for 6 transactions: grant order 0,1,0,1,0,1, and `req_ack[1]` never asserted during requester 0's ISSUE.
- Requester 1 with `read_en`=`write_en`=1: downstream `mem_write_en`=1, `mem_read_en`=0.
- `TIMEOUT_CYCLES`=4, `ack` held 0: `req_ack[0]`=`req_error[0]`=1 and `req_data_out`=0 in the 4th ISSUE cycle, then RELEASE, then IDLE.
- Requester 0 drops enables on the 2nd ISSUE cycle: no `req_ack`, RELEASE, then a pending requester 1 is granted.
- `nrst` pulsed low in ISSUE: outputs 0 asynchronously. After release, a simultaneous request from both requesters grants requester 0.
